// File: rtl/spi_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter_if
// Purpose  : Bundles the requester-side handshake, the byte-engine handshake
//            and the debug outputs of spi_bus_arbiter into one interface.
// Ports    : req_valid/req_data/req_last  -> arbiter (requesters)
//            req_ready/resp_valid/resp_data <- arbiter (requesters)
//            spi_cs_n                       <- arbiter (per-requester CS, low)
//            engine_start/engine_writeData  <- arbiter (byte engine)
//            engine_busy/engine_readData    -> arbiter (byte engine)
//            owner/active                   <- arbiter (debug)
// Modports : slave  - the arbiter itself
//            master - the surrounding requesters / engine
// Revision : 1.0 - initial release
// ============================================================================
interface spi_bus_arbiter_if #(
  parameter int REQUESTERS = 2
);
  localparam int RB = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1;

  logic [REQUESTERS-1:0]   req_valid;
  logic [8*REQUESTERS-1:0] req_data;
  logic [REQUESTERS-1:0]   req_last;
  logic [REQUESTERS-1:0]   req_ready;
  logic [REQUESTERS-1:0]   resp_valid;
  logic [7:0]              resp_data;
  logic [REQUESTERS-1:0]   spi_cs_n;
  logic                    engine_start;
  logic [7:0]              engine_writeData;
  logic                    engine_busy;
  logic [7:0]              engine_readData;
  logic [RB-1:0]           owner;
  logic                    active;

  modport slave (
    input  req_valid, req_data, req_last, engine_busy, engine_readData,
    output req_ready, resp_valid, resp_data, spi_cs_n,
           engine_start, engine_writeData, owner, active
  );

  modport master (
    output req_valid, req_data, req_last, engine_busy, engine_readData,
    input  req_ready, resp_valid, resp_data, spi_cs_n,
           engine_start, engine_writeData, owner, active
  );
endinterface
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter
// Purpose  : Shares one SPI byte-shift engine between REQUESTERS on-chip
//            requesters. Round-robin grant at burst boundaries, one active-low
//            chip select per requester, CS_DELAY cycles of CS setup before the
//            first byte and CS hold after the last byte of a burst.
// Ports    : clk  - system clock
//            rst  - asynchronous active-high reset
//            bus  - spi_bus_arbiter_if.slave (requester, engine, debug signals)
// Params   : REQUESTERS - number of requesters (2..4); must match the
//                         interface instance parameter
//            CS_DELAY   - CS setup/hold in clk cycles (1..255)
// Revision : 1.0 - initial release
// ============================================================================
module spi_bus_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int CS_DELAY   = 4
) (
  input  wire                   clk,
  input  wire                   rst,
  spi_bus_arbiter_if.slave      bus
);

  localparam int                    RB         = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1;
  localparam logic [7:0]            CS_DELAY_C = 8'(CS_DELAY);
  localparam logic [REQUESTERS-1:0] ONE        = REQUESTERS'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_START   = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_HOLD    = 3'd5,
    S_RELEASE = 3'd6
  } state_t;

  state_t                state_q;
  logic [RB-1:0]         owner_q;
  logic [RB-1:0]         last_owner_q;
  logic [7:0]            delay_q;
  logic [7:0]            tx_q;
  logic                  last_q;
  logic [REQUESTERS-1:0] cs_n_q;
  logic [REQUESTERS-1:0] req_ready_q;
  logic [REQUESTERS-1:0] resp_valid_q;
  logic [7:0]            resp_data_q;
  logic                  start_q;

  logic [RB-1:0]         grant_d;
  logic                  grant_found_d;
  logic [RB-1:0]         cand_d;
  logic                  launch_d;
  logic [7:0]            req_byte [REQUESTERS];

  // Per-requester view of the packed tx data bus.
  for (genvar g = 0; g < REQUESTERS; g++) begin : g_unpack
    assign req_byte[g] = bus.req_data[8*g +: 8];
  end

  // Round-robin search: first valid index starting just above the last owner.
  always_comb begin
    grant_d       = '0;
    grant_found_d = 1'b0;
    cand_d        = '0;
    for (int k = 1; k <= REQUESTERS; k++) begin
      cand_d = RB'((int'(last_owner_q) + k) % REQUESTERS);
      if (!grant_found_d && bus.req_valid[cand_d]) begin
        grant_d       = cand_d;
        grant_found_d = 1'b1;
      end
    end
  end

  // A byte is launched from START, from HOLD, or directly from the final
  // SETUP cycle, so that engine_start lands exactly CS_DELAY cycles after CS
  // falls when the owner is already valid.
  always_comb begin
    launch_d = 1'b0;
    if (bus.req_valid[owner_q]) begin
      launch_d = (state_q == S_START) || (state_q == S_HOLD) ||
                 ((state_q == S_SETUP) && (delay_q == 8'd1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= RB'(REQUESTERS - 1);
      delay_q      <= '0;
      tx_q         <= '0;
      last_q       <= 1'b0;
      cs_n_q       <= '1;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      start_q      <= 1'b0;
    end else begin
      // Single-cycle pulses default low.
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      start_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (|bus.req_valid) begin
            owner_q <= grant_d;
            cs_n_q  <= ~(ONE << grant_d);
            delay_q <= CS_DELAY_C;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (delay_q == 8'd1) begin
            state_q <= S_START;
          end else begin
            delay_q <= delay_q - 8'd1;
          end
        end
        S_START, S_HOLD: begin
          // Wait for the owner's next byte; CS stays asserted.
        end
        S_WAIT_HI: begin
          if (bus.engine_busy) begin
            state_q <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!bus.engine_busy) begin
            resp_data_q  <= bus.engine_readData;
            resp_valid_q <= ONE << owner_q;
            if (last_q) begin
              delay_q <= CS_DELAY_C;
              state_q <= S_RELEASE;
            end else begin
              state_q <= S_HOLD;
            end
          end
        end
        S_RELEASE: begin
          if (delay_q == 8'd1) begin
            cs_n_q       <= '1;
            last_owner_q <= owner_q;
            state_q      <= S_IDLE;
          end else begin
            delay_q <= delay_q - 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cs_n_q  <= '1;
        end
      endcase

      // Byte launch overrides the per-state next state above.
      if (launch_d) begin
        tx_q        <= req_byte[owner_q];
        last_q      <= bus.req_last[owner_q];
        req_ready_q <= ONE << owner_q;
        start_q     <= 1'b1;
        state_q     <= S_WAIT_HI;
      end
    end
  end

  assign bus.req_ready        = req_ready_q;
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_data        = resp_data_q;
  assign bus.spi_cs_n         = cs_n_q;
  assign bus.engine_start     = start_q;
  assign bus.engine_writeData = tx_q;
  assign bus.owner            = owner_q;
  assign bus.active           = (state_q != S_IDLE);

endmodule
`default_nettype wire
